coef_reload_stream: RTL and testbench
=====================================

COEF_RELOAD_STREAM -- requirements
Module: coef_reload_stream

Interface
REQ-001 SHALL have parameter NUM_COEF, default 32, number of coefficients per reload set (2..1024).
REQ-002 SHALL have parameter COEF_WIDTH, default 16, coefficient width in bits (1..32).
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, AXI4-Lite address width (>=4).
REQ-004 SHALL have port s00_axi_aclk, in, 1, single clock for all logic.
REQ-005 SHALL have port s00_axi_aresetn, in, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have AXI4-Lite write address channel s00_axi_awaddr/awprot/awvalid (in), awready (out).
REQ-007 SHALL have AXI4-Lite write data channel s00_axi_wdata[31:0]/wstrb[3:0]/wvalid (in), wready (out).
REQ-008 SHALL have AXI4-Lite write response channel s00_axi_bresp[1:0]/bvalid (out), bready (in).
REQ-009 SHALL have AXI4-Lite read channels s00_axi_araddr/arprot/arvalid/rready (in), arready/rdata[31:0]/rresp[1:0]/rvalid (out).
REQ-010 SHALL have m_axis_reload_tdata[COEF_WIDTH-1:0]/tvalid/tlast (out) and m_axis_reload_tready (in): coefficient stream to FIR.
REQ-011 SHALL have m_axis_config_tdata[7:0]/tvalid (out) and m_axis_config_tready (in): reload commit to FIR.

Function
REQ-012 Register map (byte offset): 0x0 CTRL (W: bit0 START, bit1 DONE_CLR, bit2 ERR_CLR; reads 0); 0x4 STATUS (R: bit0 BUSY, bit1 DONE, bit2 ERR); 0x8 INDEX (R/W, clog2(NUM_COEF) bits); 0xC DATA; other offsets read 0, writes ignored, OKAY.
REQ-013 Write: awready and wready SHALL pulse together one cycle when awvalid and wvalid are both high and bvalid is low; bvalid asserted next cycle, held until bready.
REQ-014 Read: arready SHALL pulse one cycle when arvalid high and rvalid low; rdata/rvalid registered next cycle; rvalid held until rready; rdata stable while rvalid.
REQ-015 wstrb SHALL be ignored (full-word writes); awprot/arprot ignored.
REQ-016 DATA write when idle SHALL store wdata[COEF_WIDTH-1:0] into shadow[INDEX] and increment INDEX, wrapping NUM_COEF-1 -> 0; bresp OKAY.
REQ-017 DATA write while BUSY SHALL not modify shadow or INDEX, SHALL return bresp SLVERR (2'b10) and set ERR.
REQ-018 INDEX write with value >= NUM_COEF SHALL leave INDEX unchanged, return SLVERR, set ERR.
REQ-019 Reload FSM states IDLE, LOAD, CFG; START in IDLE -> LOAD with k=0, BUSY=1; START while BUSY SHALL be ignored and set ERR.
REQ-020 LOAD: tvalid=1, tdata=shadow[k], tlast=(k==NUM_COEF-1); k advances on tvalid&tready; beat with tlast accepted -> CFG; tvalid never deasserted before acceptance.
REQ-021 CFG: config_tvalid=1, config_tdata=8'h00 until config_tready; then IDLE, BUSY=0, DONE=1.
REQ-022 DONE and ERR SHALL be sticky, cleared only by DONE_CLR/ERR_CLR writes; set and clear in same cycle -> set wins.
REQ-023 Latency: first reload tvalid SHALL assert the cycle after the START write handshake; with tready tied high, BUSY deasserts NUM_COEF+2 cycles after that.

Reset
REQ-024 While s00_axi_aresetn low: all ready/valid outputs, tlast, bresp, rresp, rdata, tdata=0; INDEX=0; BUSY/DONE/ERR=0; FSM=IDLE.
REQ-025 Shadow memory SHALL NOT be reset; reset mid-LOAD/CFG aborts the reload with no further beats and no config commit.

Configuration
REQ-026 Macro COEF_RELOAD_READBACK_EN defined: DATA read SHALL return shadow[INDEX] zero-extended to 32 bits, INDEX unchanged by reads.
REQ-027 Macro COEF_RELOAD_READBACK_EN undefined: DATA read SHALL return 0 with OKAY; shadow memory is write-only (single read port, used by LOAD).

Verification
REQ-028 NUM_COEF=4: write INDEX=0, DATA 1,2,3,4, START, tready=1 -> tdata 1,2,3,4, tlast on 4th, one config beat 8'h00, STATUS=0x2.
REQ-029 Backpressure: reload_tready toggled every other cycle -> same 4 beats in order, tvalid/tdata stable while stalled.
REQ-030 DATA write and START during LOAD -> bresp SLVERR for DATA, shadow unchanged, STATUS=0x5, no second reload.
REQ-031 INDEX=3 then 2 DATA writes (NUM_COEF=4) -> INDEX reads 1; INDEX write 4 -> SLVERR, INDEX stays 1.
REQ-032 READBACK_EN: write INDEX=2, read DATA -> 3; without macro -> 0.
REQ-033 Reset asserted after 2nd reload beat -> all outputs 0 immediately, no config beat, STATUS=0 after release.

Source files
------------

// File: rtl/coef_reload_stream.sv
// coef_reload_stream: AXI4-Lite register front end that fills a coefficient
// shadow memory and, on START, streams the whole set to a FIR reload port
// followed by a single config commit beat.
// Optional build macro: COEF_RELOAD_READBACK_EN adds a DATA read path that
// returns shadow[INDEX]; without it the shadow memory is write-only.
module coef_reload_stream #(
    parameter int NUM_COEF           = 32,
    parameter int COEF_WIDTH         = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [2:0]                    s00_axi_awprot,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [31:0]                   s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [2:0]                    s00_axi_arprot,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [31:0]                   s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    output logic [COEF_WIDTH-1:0]         m_axis_reload_tdata,
    output logic                          m_axis_reload_tvalid,
    output logic                          m_axis_reload_tlast,
    input  logic                          m_axis_reload_tready,
    output logic [7:0]                    m_axis_config_tdata,
    output logic                          m_axis_config_tvalid,
    input  logic                          m_axis_config_tready
);

    localparam int SEL_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int IDX_W = $clog2(NUM_COEF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);
    localparam logic [SEL_W-1:0] REG_CTRL   = SEL_W'(0);
    localparam logic [SEL_W-1:0] REG_STATUS = SEL_W'(1);
    localparam logic [SEL_W-1:0] REG_INDEX  = SEL_W'(2);
    localparam logic [SEL_W-1:0] REG_DATA   = SEL_W'(3);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CFG} state_t;

    state_t                  state_q, state_d;
    logic                    awready_q, awready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [COEF_WIDTH-1:0]   shadow_q [NUM_COEF];

    logic                    wr_hs, rd_hs;
    logic [SEL_W-1:0]        wsel, rsel;
    logic [1:0]              wr_resp;
    logic                    start_req, start_go, done_clr, err_clr, err_set;
    logic                    shadow_we;
    logic                    busy, done_set, beat_acc;
    logic [31:0]             rd_mux;
    logic                    unused_ok;

    // Protection, strobes and byte-lane address bits carry no meaning here.
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0], s00_axi_wdata};

    assign wsel = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rsel = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    assign s00_axi_awready     = awready_q;
    assign s00_axi_wready      = awready_q;
    assign s00_axi_bvalid      = bvalid_q;
    assign s00_axi_bresp       = bresp_q;
    assign s00_axi_arready     = arready_q;
    assign s00_axi_rvalid      = rvalid_q;
    assign s00_axi_rdata       = rdata_q;
    assign s00_axi_rresp       = RESP_OKAY;
    assign m_axis_config_tdata = 8'h00;

    // Register write decode: side effects and response code for one handshake.
    always_comb begin
        wr_hs     = awready_q & s00_axi_awvalid & s00_axi_wvalid;
        wr_resp   = RESP_OKAY;
        start_req = 1'b0;
        done_clr  = 1'b0;
        err_clr   = 1'b0;
        err_set   = 1'b0;
        shadow_we = 1'b0;
        index_d   = index_q;
        if (wr_hs) begin
            if (wsel == REG_CTRL) begin
                start_req = s00_axi_wdata[0];
                done_clr  = s00_axi_wdata[1];
                err_clr   = s00_axi_wdata[2];
                if (s00_axi_wdata[0] && busy) err_set = 1'b1;
            end else if (wsel == REG_INDEX) begin
                if (s00_axi_wdata >= 32'(NUM_COEF)) begin
                    wr_resp = RESP_SLVERR;
                    err_set = 1'b1;
                end else begin
                    index_d = s00_axi_wdata[IDX_W-1:0];
                end
            end else if (wsel == REG_DATA) begin
                if (busy) begin
                    wr_resp = RESP_SLVERR;
                    err_set = 1'b1;
                end else begin
                    shadow_we = 1'b1;
                    index_d   = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
                end
            end
        end
    end

    // AXI handshake sequencing: one-cycle ready pulses, held responses.
    always_comb begin
        awready_d = ~awready_q & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_resp;
        end else if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
            bresp_d  = RESP_OKAY;
        end
        rd_hs     = arready_q & s00_axi_arvalid;
        arready_d = ~arready_q & s00_axi_arvalid & ~rvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (rd_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Read data selection for the addressed register.
    always_comb begin
        rd_mux = 32'h0;
        if (rsel == REG_STATUS) begin
            rd_mux = {29'h0, err_q, done_q, busy};
        end else if (rsel == REG_INDEX) begin
            rd_mux = 32'(index_q);
        end else if (rsel == REG_DATA) begin
`ifdef COEF_RELOAD_READBACK_EN
            rd_mux = 32'(shadow_q[index_q]);
`else
            rd_mux = 32'h0;
`endif
        end
    end

    // Sticky status flags and beat counter; a set in the same cycle as a clear wins.
    always_comb begin
        start_go = start_req & ~busy;
        beat_acc = (state_q == S_LOAD) & m_axis_reload_tready;
        done_d   = done_set | (done_q & ~done_clr);
        err_d    = err_set | (err_q & ~err_clr);
        k_d      = k_q;
        if (start_go) begin
            k_d = '0;
        end else if (beat_acc) begin
            k_d = (k_q == LAST_IDX) ? '0 : k_q + 1'b1;
        end
    end

    // Reload FSM: state register.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reload FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_go) state_d = S_LOAD;
            S_LOAD:  if (beat_acc && (k_q == LAST_IDX)) state_d = S_CFG;
            S_CFG:   if (m_axis_config_tready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reload FSM: outputs; data is forced to zero outside LOAD.
    always_comb begin
        busy                 = (state_q != S_IDLE);
        m_axis_reload_tvalid = (state_q == S_LOAD);
        m_axis_reload_tlast  = (state_q == S_LOAD) && (k_q == LAST_IDX);
        m_axis_reload_tdata  = (state_q == S_LOAD) ? shadow_q[k_q] : '0;
        m_axis_config_tvalid = (state_q == S_CFG);
        done_set             = (state_q == S_CFG) && m_axis_config_tready;
    end

    // Control and AXI response registers.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            index_q   <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            index_q   <= index_d;
            k_q       <= k_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Shadow coefficient memory keeps its contents across reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (shadow_we) shadow_q[index_q] <= s00_axi_wdata[COEF_WIDTH-1:0];
    end

endmodule

// File: tb/tb_coef_reload_stream.sv
// Bench for coef_reload_stream with a 4-coefficient set: AXI-Lite register
// access, reload streaming with a beat scoreboard, backpressure, error paths
// and reset abort.
module tb_coef_reload_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [15:0] tdata;
    logic        tvalid, tready, tlast;
    logic [7:0]  cdata;
    logic        cvalid, cready;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          beat_cnt = 0;
    int          rise_cyc = 0;
    int          cfg_cyc = 0;
    logic [16:0] sb_q[$];
    logic [7:0]  cfg_q[$];
    logic        prev_stall = 1'b0;
    logic        prev_tv = 1'b0;
    logic [15:0] prev_data = '0;
    logic [15:0] mdl [4];
    int          midx = 0;

    always #5 clk = ~clk;

    coef_reload_stream #(.NUM_COEF(4), .COEF_WIDTH(16), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .m_axis_reload_tdata(tdata), .m_axis_reload_tvalid(tvalid),
        .m_axis_reload_tlast(tlast), .m_axis_reload_tready(tready),
        .m_axis_config_tdata(cdata), .m_axis_config_tvalid(cvalid),
        .m_axis_config_tready(cready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: scoreboard pop on every accepted beat, hold check while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
            prev_tv    <= 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("hold_tvalid", 32'(tvalid), 32'd1);
                check_val("hold_tdata", 32'(tdata), 32'(prev_data));
            end
            if (tvalid && !prev_tv) rise_cyc <= cyc;
            if (tvalid && tready) begin
                logic [16:0] e;
                beat_cnt <= beat_cnt + 1;
                check_val("beat_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_val("beat_tdata", 32'(tdata), 32'(e[15:0]));
                    check_val("beat_tlast", 32'(tlast), 32'(e[16]));
                end
            end
            if (cvalid && cready) begin
                logic [7:0] c;
                cfg_cyc <= cyc;
                check_val("cfg_expected", 32'(cfg_q.size() != 0), 32'd1);
                if (cfg_q.size() != 0) begin
                    c = cfg_q.pop_front();
                    check_val("cfg_tdata", 32'(cdata), 32'(c));
                end
            end
            prev_stall <= tvalid & ~tready;
            prev_data  <= tdata;
            prev_tv    <= tvalid;
        end
    end

    task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
        bit ok = 0;
        resp = 2'bxx;
        awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        check_val("aw_handshake", 32'(ok), 32'd1);
        check_val("wready_with_awready", 32'(wready), 32'(awready));
        @(posedge clk); #1;
        hs_cyc = cyc;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1; resp = bresp; break; end
        end
        check_val("b_handshake", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
        bit ok = 0;
        d = 'x;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        check_val("ar_handshake", 32'(ok), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1; d = rdata; break; end
        end
        check_val("r_handshake", 32'(ok), 32'd1);
        check_val("rresp", 32'(rresp), 32'd0);
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [3:0] a, input logic [31:0] d,
                          input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_wr(a, d, r);
        check_val(tag, 32'(r), 32'(exp_resp));
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_rd(a, d);
        check_val(tag, d, exp);
    endtask

    task automatic idx_wr(input logic [31:0] v);
        if (v < 4) begin
            wr_chk("index_wr_okay", 4'h8, v, 2'b00);
            midx = int'(v);
        end else begin
            wr_chk("index_wr_slverr", 4'h8, v, 2'b10);
        end
    endtask

    task automatic data_wr(input logic [15:0] v);
        wr_chk("data_wr_okay", 4'hC, {16'h0, v}, 2'b00);
        mdl[midx] = v;
        midx = (midx + 1) % 4;
    endtask

    task automatic expect_reload();
        for (int i = 0; i < 4; i++) sb_q.push_back({(i == 3), mdl[i]});
        cfg_q.push_back(8'h00);
    endtask

    task automatic wait_drain(input bit toggle);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (toggle) tready = ~tready;
            if (sb_q.size() == 0 && cfg_q.size() == 0) begin ok = 1; break; end
        end
        check_val("drain", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_handshakes"},
                  32'({awready, wready, bvalid, arready, rvalid, tvalid, tlast, cvalid}), 32'd0);
        check_val({tag, "_bresp"}, 32'(bresp), 32'd0);
        check_val({tag, "_rresp"}, 32'(rresp), 32'd0);
        check_val({tag, "_rdata"}, rdata, 32'd0);
        check_val({tag, "_tdata"}, 32'(tdata), 32'd0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        tready = 1'b1; cready = 1'b1;
        #22;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_chk("status_after_reset", 4'h4, 32'h0);
        rd_chk("index_after_reset", 4'h8, 32'h0);

        // Basic reload with tready tied high, plus latency.
        idx_wr(0);
        data_wr(16'd1); data_wr(16'd2); data_wr(16'd3); data_wr(16'd4);
        rd_chk("index_wrapped", 4'h8, 32'h0);
        expect_reload();
        wr_chk("start_okay", 4'h0, 32'h1, 2'b00);
        wait_drain(1'b0);
        check_val("first_tvalid_latency", 32'(rise_cyc), 32'(hs_cyc));
        check_val("cfg_commit_latency", 32'(cfg_cyc), 32'(hs_cyc + 4));
        rd_chk("status_done", 4'h4, 32'h2);
        rd_chk("ctrl_reads_zero", 4'h0, 32'h0);

        // Readback of shadow[2].
        idx_wr(2);
`ifdef COEF_RELOAD_READBACK_EN
        rd_chk("data_readback", 4'hC, 32'd3);
`else
        rd_chk("data_readback", 4'hC, 32'd0);
`endif
        rd_chk("index_unchanged_by_read", 4'h8, 32'd2);
        wr_chk("done_clr", 4'h0, 32'h2, 2'b00);
        rd_chk("status_cleared", 4'h4, 32'h0);

        // Backpressure: tready toggles every cycle.
        idx_wr(0);
        data_wr(16'd10); data_wr(16'd20); data_wr(16'd30); data_wr(16'd40);
        tready = 1'b0;
        expect_reload();
        wr_chk("start_bp", 4'h0, 32'h1, 2'b00);
        wait_drain(1'b1);
        tready = 1'b1;
        rd_chk("status_done_bp", 4'h4, 32'h2);
        wr_chk("done_clr_bp", 4'h0, 32'h2, 2'b00);

        // DATA write and START while a reload is stalled mid-LOAD.
        tready = 1'b0;
        expect_reload();
        wr_chk("start_stalled", 4'h0, 32'h1, 2'b00);
        wr_chk("data_wr_busy_slverr", 4'hC, 32'hBEEF, 2'b10);
        wr_chk("start_while_busy", 4'h0, 32'h1, 2'b00);
        rd_chk("status_busy_err", 4'h4, 32'h5);
        tready = 1'b1;
        wait_drain(1'b0);
        repeat (10) @(posedge clk);
        #1;
        rd_chk("status_done_err", 4'h4, 32'h6);
        rd_chk("index_untouched_busy", 4'h8, 32'h0);
        wr_chk("clear_both", 4'h0, 32'h6, 2'b00);
        rd_chk("status_clear_both", 4'h4, 32'h0);

        // INDEX wrap through DATA writes and out-of-range INDEX write.
        idx_wr(3);
        data_wr(16'd5); data_wr(16'd6);
        rd_chk("index_after_wrap", 4'h8, 32'd1);
        idx_wr(4);
        rd_chk("index_kept", 4'h8, 32'd1);
        rd_chk("status_err_index", 4'h4, 32'h4);
        wr_chk("err_clr", 4'h0, 32'h4, 2'b00);

        // Reset after the second reload beat aborts the reload.
        tready = 1'b1;
        base = beat_cnt;
        expect_reload();
        wr_chk("start_before_reset", 4'h0, 32'h1, 2'b00);
        begin
            bit ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(posedge clk);
                if (beat_cnt >= base + 2) begin ok = 1; break; end
            end
            check_val("two_beats_before_reset", 32'(ok), 32'd1);
        end
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reload_reset");
        sb_q.delete();
        cfg_q.delete();
        #30;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_chk("status_after_abort", 4'h4, 32'h0);
        rd_chk("index_after_abort", 4'h8, 32'h0);
        repeat (10) @(posedge clk);
        #1;

        // Shadow contents survive reset.
        midx = 0;
        expect_reload();
        wr_chk("start_after_reset", 4'h0, 32'h1, 2'b00);
        wait_drain(1'b0);
        rd_chk("status_done_final", 4'h4, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
